// File: rtl/microseq_control_unit.sv
// Microcode-programmable control unit: sequences each opcode class through
// up to 2^STEP_W control steps read from a writable store indexed by
// {opcode, step}. Supports a datapath stall, a pipeline flush, and an
// instruction-done strobe. A single idle cycle follows every reset.
module microseq_control_unit #(
  parameter int OPC_W  = 4,
  parameter int STEP_W = 2,
  parameter int CTRL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPC_W-1:0]        opcode_in,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    ucode_we,
  input  logic [OPC_W+STEP_W-1:0] ucode_addr,
  input  logic [CTRL_W:0]         ucode_wdata,
  output logic [CTRL_W-1:0]       ctrl_bus,
  output logic [STEP_W-1:0]       step,
  output logic                    bubble,
  output logic                    instr_done
);

  localparam int ADDR_W = OPC_W + STEP_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    PH_BUBBLE,
    PH_RUN
  } phase_t;

  phase_t              phase_q, phase_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [CTRL_W:0]     store [DEPTH];
  logic [CTRL_W:0]     entry;
  logic [OPC_W-1:0]    eff_opc;
  logic                in_bubble;
  logic                done;

  // Sequencer state: phase, step counter and latched opcode (async reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_BUBBLE;
      step_q  <= '0;
      opc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      opc_q   <= opc_d;
    end
  end

  // Microcode store write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ucode_we) begin
      store[ucode_addr] <= ucode_wdata;
    end
  end

  // Entry lookup, output gating and next-state selection
  always_comb begin
    phase_d   = PH_RUN;
    step_d    = step_q;
    opc_d     = opc_q;
    in_bubble = (phase_q == PH_BUBBLE);
    eff_opc   = (step_q == '0) ? opcode_in : opc_q;
    entry     = store[{eff_opc, step_q}];
    done      = !rst && !in_bubble && !stall && (entry[CTRL_W] || (step_q == '1));
    ctrl_bus  = (rst || in_bubble || stall) ? '0 : entry[CTRL_W-1:0];

    // Opcode is captured on every step-0 edge that actually advances;
    // stall is not honoured during the bubble.
    if ((step_q == '0) && (in_bubble || !stall)) begin
      opc_d = opcode_in;
    end

    if (in_bubble) begin
      step_d = '0;
    end else if (flush) begin
      step_d = '0;
    end else if (stall) begin
      step_d = step_q;
    end else if (done) begin
      step_d = '0;
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  assign step       = step_q;
  assign bubble     = in_bubble;
  assign instr_done = done;

endmodule

// File: tb/tb_microseq_control_unit.sv
// Self-checking bench for microseq_control_unit: directed scenarios followed
// by randomized traffic, all compared against a cycle-level reference model.
module tb_microseq_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ucode_we = 1'b0;
  logic [5:0]  ucode_addr = '0;
  logic [16:0] ucode_wdata = '0;
  logic [15:0] ctrl_bus;
  logic [1:0]  step;
  logic        bubble;
  logic        instr_done;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] m_ctrl [64];
  bit          m_last [64];
  int          m_step = 0;
  logic [3:0]  m_opc  = '0;
  bit          m_bub  = 1'b1;

  // last observed outputs, for directed literal checks
  logic [31:0] obs_ctrl, obs_done, obs_step, obs_bub;

  logic [16:0] tbl [64];

  microseq_control_unit #(
    .OPC_W (4),
    .STEP_W(2),
    .CTRL_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_in  (opcode_in),
    .stall      (stall),
    .flush      (flush),
    .ucode_we   (ucode_we),
    .ucode_addr (ucode_addr),
    .ucode_wdata(ucode_wdata),
    .ctrl_bus   (ctrl_bus),
    .step       (step),
    .bubble     (bubble),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance model at posedge.
  task automatic cycle(input bit r, input logic [3:0] op, input bit st, input bit fl,
                       input bit we, input logic [5:0] wa, input logic [16:0] wd);
    int          idx;
    int          nstep;
    logic [3:0]  eff;
    bit          lst;
    bit          e_done;
    logic [15:0] e_ctrl;
    @(negedge clk);
    rst = r; opcode_in = op; stall = st; flush = fl;
    ucode_we = we; ucode_addr = wa; ucode_wdata = wd;
    if (r) begin
      m_step = 0; m_opc = '0; m_bub = 1'b1;
    end
    #1;
    eff    = (m_step == 0) ? op : m_opc;
    idx    = int'(eff) * 4 + m_step;
    lst    = m_last[idx] || (m_step == 3);
    e_done = !r && !m_bub && !st && lst;
    e_ctrl = (r || m_bub || st) ? 16'h0 : m_ctrl[idx];
    chk("ctrl_bus", 32'(ctrl_bus), 32'(e_ctrl));
    chk("instr_done", 32'(instr_done), 32'(e_done));
    chk("step", 32'(step), 32'(m_step));
    chk("bubble", 32'(bubble), 32'(m_bub));
    obs_ctrl = 32'(ctrl_bus); obs_done = 32'(instr_done);
    obs_step = 32'(step);     obs_bub  = 32'(bubble);
    if (r || m_bub || fl || e_done) nstep = 0;
    else if (st)                    nstep = m_step;
    else                            nstep = (m_step + 1) % 4;
    @(posedge clk);
    if (!r) begin
      if (m_step == 0 && (m_bub || !st)) m_opc = op;
      m_step = nstep;
      m_bub  = 1'b0;
    end
    if (we) begin
      m_ctrl[wa] = wd[15:0];
      m_last[wa] = wd[16];
    end
  endtask

  task automatic run(input logic [3:0] op, input bit st, input bit fl);
    cycle(1'b0, op, st, fl, 1'b0, 6'd0, 17'd0);
  endtask

  initial begin
    // microcode image: random background plus directed programs
    for (int a = 0; a < 64; a++) tbl[a] = 17'($urandom);
    tbl[{4'h0, 2'd0}] = {1'b1, 16'h0018};
    tbl[{4'h3, 2'd0}] = {1'b0, 16'h0200};
    tbl[{4'h3, 2'd1}] = {1'b1, 16'h0112};
    tbl[{4'h5, 2'd0}] = {1'b0, 16'h0001};
    tbl[{4'h5, 2'd1}] = {1'b0, 16'h0002};
    tbl[{4'h5, 2'd2}] = {1'b0, 16'h0004};
    tbl[{4'h5, 2'd3}] = {1'b0, 16'h0008};

    // reset held three cycles
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 6'd0, 17'd0);
    // bubble cycle after release; store loaded while stalled
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 6'd0, 17'd0);
    chk("bubble_first", obs_bub, 32'd1);
    chk("bubble_ctrl", obs_ctrl, 32'd0);
    for (int a = 0; a < 64; a++)
      cycle(1'b0, 4'($urandom), 1'b1, 1'b0, 1'b1, 6'(a), tbl[a]);
    chk("bubble_cleared", obs_bub, 32'd0);

    // single-cycle op
    for (int i = 0; i < 4; i++) begin
      run(4'h0, 1'b0, 1'b0);
      chk("single_ctrl", obs_ctrl, 32'h0018);
      chk("single_done", obs_done, 32'd1);
      chk("single_step", obs_step, 32'd0);
    end

    // two-step op, opcode changes during step 1
    run(4'h3, 1'b0, 1'b0);
    chk("two_s0", obs_ctrl, 32'h0200);
    run(4'h0, 1'b0, 1'b0);
    chk("two_s1", obs_ctrl, 32'h0112);
    chk("two_done", obs_done, 32'd1);
    run(4'h0, 1'b0, 1'b0);
    chk("two_next", obs_ctrl, 32'h0018);

    // stall in step 1
    run(4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      run(4'h0, 1'b1, 1'b0);
      chk("stall_ctrl", obs_ctrl, 32'd0);
      chk("stall_step", obs_step, 32'd1);
      chk("stall_done", obs_done, 32'd0);
    end
    run(4'h0, 1'b0, 1'b0);
    chk("stall_rel_ctrl", obs_ctrl, 32'h0112);
    chk("stall_rel_done", obs_done, 32'd1);

    // full four-step wrap
    for (int i = 0; i < 4; i++) begin
      run(4'h5, 1'b0, 1'b0);
      chk("wrap_ctrl", obs_ctrl, 32'(1 << i));
      chk("wrap_done", obs_done, (i == 3) ? 32'd1 : 32'd0);
    end
    run(4'h0, 1'b0, 1'b0);
    chk("wrap_back", obs_step, 32'd0);

    // flush at step 1, then flush+stall at step 1
    run(4'h5, 1'b0, 1'b0);
    run(4'h5, 1'b0, 1'b1);
    chk("flush_at_s1", obs_step, 32'd1);
    run(4'h3, 1'b0, 1'b0);
    chk("flush_step0", obs_step, 32'd0);
    chk("flush_fresh", obs_ctrl, 32'h0200);
    run(4'h0, 1'b1, 1'b1);
    chk("flstall_ctrl", obs_ctrl, 32'd0);
    run(4'h0, 1'b0, 1'b0);
    chk("flstall_step", obs_step, 32'd0);

    // write-read hazard on the active entry
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, {4'h0, 2'd0}, {1'b1, 16'hABCD});
    chk("hazard_old", obs_ctrl, 32'h0018);
    run(4'h0, 1'b0, 1'b0);
    chk("hazard_new", obs_ctrl, 32'hABCD);

    // asynchronous reset in the middle of step 1
    run(4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 6'd0, 17'd0);
    chk("arst_step", obs_step, 32'd0);
    chk("arst_bubble", obs_bub, 32'd1);
    cycle(1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 6'd0, 17'd0);
    chk("arst_bub_cycle", obs_bub, 32'd1);
    run(4'h3, 1'b0, 1'b0);
    chk("arst_store_kept", obs_ctrl, 32'h0200);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(99) == 0), 4'($urandom), ($urandom_range(4) == 0),
            ($urandom_range(11) == 0), ($urandom_range(7) == 0),
            6'($urandom), 17'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/microseq_control_unit.md
Name: microseq_control_unit

Overview:
- Parametrised, microcode-programmable successor to the FRANK6000 fixed-table control unit.
- Sequences each instruction class through 1..2^STEP_W control steps. The sequence is read from an internal writable microcode store indexed by {opcode, step}.
- Adds the following: latched opcode for multi-cycle instructions, a datapath stall, a pipeline flush, and an instruction-done strobe.
- Sits between the instruction decoder (opcode class) and the datapath control bus.

Parameters:
- OPC_W, 4, opcode-class width; number of classes = 2^OPC_W.
- STEP_W, 2, step counter width; maximum steps per instruction = 2^STEP_W.
- CTRL_W, 16, control bus width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode_in  in  OPC_W  instruction class from the decoder. Sampled at step 0.
- stall  in  1  datapath not ready. Freezes sequencing.
- flush  in  1  abort the current instruction and return to step 0.
- ucode_we  in  1  microcode write enable.
- ucode_addr  in  OPC_W+STEP_W  write address = {opcode, step}.
- ucode_wdata  in  CTRL_W+1  bit CTRL_W is the "last" flag; bits CTRL_W-1:0 are the control word.
- ctrl_bus  out  CTRL_W  control word for the current step.
- step  out  STEP_W  current step index.
- bubble  out  1  high during the post-reset idle cycle.
- instr_done  out  1  the current step completes the instruction this cycle.

Behaviour:
- State registers: step counter, latched opcode (opc_q), bubble flag, microcode store of 2^(OPC_W+STEP_W) entries × (CTRL_W+1) bits.
- The microcode store is not reset. Software/bench loads it before use.
- Async reset values: step=0, opc_q=0, bubble=1. Outputs while rst=1: ctrl_bus=0, instr_done=0, bubble=1.
- Bubble cycle:
  - First clock edge after rst deasserts: ctrl_bus=0, instr_done=0.
  - Next edge clears bubble; step stays 0.
  - stall and flush are ignored during the bubble.
- Effective opcode: opcode_in when step==0, else opc_q. At every non-stalled step-0 edge, opc_q <= opcode_in.
- Entry read: entry = store[{eff_opcode, step}], combinational, zero latency.
- ctrl_bus:
  - = entry control word when not bubble and not stall.
  - = 0 during bubble or stall, so no datapath writes commit.
- instr_done = entry.last OR (step==2^STEP_W-1), gated off by bubble, stall and rst.
- Next step, in priority order:
  1. rst → 0.
  2. bubble → 0.
  3. flush → 0. Flush overrides stall; opc_q is unchanged.
  4. stall → hold.
  5. instr_done → 0.
  6. Otherwise step+1.
- Wrap: a sequence with no last flag runs all 2^STEP_W steps, then returns to step 0 (instr_done forced at the final step).
- Microcode write:
  - Commits at the rising edge when ucode_we=1.
  - A read of the same entry in the same cycle returns the old value; the new value is visible from the next cycle.
  - Writes are permitted during bubble, stall and normal operation.
- Reset mid-instruction: immediate return to reset values (async). opc_q is lost. The store is unchanged.
- Combinational opcode_in→ctrl_bus path exists at step 0 only.

Test Plan:
- Reset/bubble: hold rst 3 cycles, release → ctrl_bus=0, bubble=1 for 1 cycle, then bubble=0, step=0. Assert rst mid-step 1 → step=0, bubble=1 immediately, without waiting for a clock edge.
- Single-cycle op: write {4'h0,2'd0}={1,16'h0018}; opcode_in=0 for 4 cycles → ctrl_bus=0x0018, instr_done=1, step=0 every cycle.
- Two-step op with opcode latch: write {3,0}={0,0x0200} and {3,1}={1,0x0112}. Apply opcode_in=3, then switch opcode_in to 0 during step 1 → ctrl_bus 0x0200, then 0x0112 (instr_done=1), then 0x0018.
- Stall: during step 1 of opcode 3, stall=1 for 2 cycles → ctrl_bus=0, step=1, instr_done=0 for both cycles. Release → ctrl_bus=0x0112, instr_done=1.
- Flush and wrap:
  - Program opcode 5 with all four entries last=0 and ctrl 0x0001/0x0002/0x0004/0x0008 → sequence 0x0001, 0x0002, 0x0004, 0x0008, with instr_done=1 only at step 3, then step 0.
  - Rerun opcode 5 with flush=1 at step 1 → next cycle step=0 with a fresh opcode sample. Flush+stall at the same time → step=0.
- Write-read hazard: write {0,0}={1,0xABCD} while executing opcode 0 at step 0 → that cycle ctrl_bus=0x0018, next cycle 0xABCD.
